seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed seven-segment display controller for the npc board top.
- Drives NDIG digits through one shared active-low segment bus plus active-low per-digit anode selects.
- Accepts a packed nibble word over a valid/ready handshake and commits it only at frame boundaries, so the display never tears.
- Adds a hex/decimal decode mode, leading-zero blanking, per-digit blink and anti-ghosting blank cycles.

Parameters:
- NDIG, 8: number of digits; legal range 2..16.
- CLK_DIV, 1000: clock cycles per digit slot; minimum 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a new display word is offered.
- in_ready  out  1  the controller can accept a word; equals !pending (combinational).
- in_data  in  4*NDIG  nibble i sits at bits [4i+3:4i]; digit 0 is least significant.
- in_hex  in  1  1 = hex glyphs 0-F; 0 = decimal, where nibbles above 9 are blank.
- in_lzb  in  1  leading-zero blanking enable.
- in_blink  in  NDIG  per-digit blink mask.
- seg_n  out  7  active-low segments, bit6 = a through bit0 = g; registered.
- an_n  out  NDIG  active-low one-hot digit select; registered.

Behaviour:
- Reset clears everything: presc=0, idx=0, frame_cnt=0, phase=0, pending=0.
- Reset also clears the display registers and the pending buffer: digits, hex, lzb and blink all 0.
- Reset output values: an_n=all 1, seg_n=7'h7F, in_ready=1.
- Reset during operation discards any pending word and any displayed word.
- Prescaler:
  - presc counts 0..CLK_DIV-1 and wraps.
  - tick = (presc==CLK_DIV-1).
  - On tick, idx advances and wraps from NDIG-1 to 0.
  - frame_end = tick && idx==NDIG-1.
- Handshake:
  - Accept when in_valid && in_ready.
  - On accept, in_data, in_hex, in_lzb and in_blink are captured into the pending buffer, and pending is set to 1.
  - in_valid is ignored while in_ready=0; the source holds its data.
- Commit:
  - On frame_end with pending=1, the pending buffer copies into the display registers and pending clears.
  - in_ready rises the following cycle.
  - The new word is first visible in digit 0's slot.
- Blink:
  - On frame_end, frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1, it wraps to 0 and phase toggles.
- Output register, updated every cycle:
  - On a tick cycle, the next outputs are blank: an_n=all 1, seg_n=7F.
  - Otherwise the next outputs are an_n = ~(1<<idx) and seg_n = glyph(digit[idx]).
  - The output therefore lags idx by one cycle, and each slot shows a blank first cycle followed by CLK_DIV-1 lit cycles.
- Digit suppression: digit i is dark (an_n bit high, seg_n=7F) when any of these holds:
  - blink[i]=1 and phase=1;
  - lzb=1, i!=0, and digits i..NDIG-1 are all zero. Digit 0 is never LZ-blanked.
- Glyphs (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Decimal mode with a nibble above 9: seg_n=7F with the anode still driven.
- Simultaneous events:
  - Accept and frame_end in the same cycle can only occur with pending=0. The capture then happens and the commit waits for the next frame_end.
  - When a commit occurs, the blink counter still advances in the same cycle.

Test Plan:
1. Reset/scan, with NDIG=4, CLK_DIV=4, no load: outputs are an_n=1111 and seg_n=7F during reset. Afterward each slot shows 1 blank cycle then 3 cycles of an_n=1110/1101/1011/0111, each with seg_n=0000001.
2. Decimal load: 0x1234 with hex=0, accepted mid-frame. Display stays "0000" until the frame end. The next frame shows an_n=1110 with seg_n=1001100 (4), up to an_n=0111 with seg_n=1001111 (1).
3. Hex mode: 0xABCD with hex=1 shows digit3=0001000 through digit0=1000010. The same word with hex=0 gives seg_n=7F on all four slots.
4. Leading-zero blanking: 0x0070 with lzb=1 keeps an_n bits 3 and 2 high, shows digit1=0001111 and digit0=0000001. A load of 0x0000 shows digit 0 only.
5. Backpressure: two back-to-back valid words 0x1111 then 0x2222. The first is accepted and in_ready=0 until one cycle after frame_end. The second is accepted then and appears one frame later; 0x1111 is shown for exactly one full frame.
6. Blink: BLINK_FRAMES=2, blink=0001, digits 0x5555. Digit 0 is lit for 2 frames then dark for 2 frames, repeating. Digits 1-3 stay lit at 0100100. Asserting rst mid-blink immediately gives an_n=1111 and in_ready=1.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// -----------------------------------------------------------------------------
// Time-multiplexed seven-segment display controller.
//
// A packed nibble word arrives over a valid/ready handshake and is held in a
// pending buffer. It is moved into the display registers only at a scan frame
// boundary, so a frame never shows a mix of the old and the new word. The
// scanner walks the digits one slot at a time. Each slot is CLK_DIV cycles
// long, and its first cycle is blanked to suppress ghosting between digits.
//
// Parameters
//   NDIG          number of digits (2..16)
//   CLK_DIV       clock cycles per digit slot (>= 2)
//   BLINK_FRAMES  scan frames per blink half-period (>= 1)
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   in_valid  a new display word is offered
//   in_ready  word can be accepted (== !pending, combinational)
//   in_data   packed nibbles, digit i at [4i+3:4i], digit 0 least significant
//   in_hex    1 = hex glyphs 0-F, 0 = decimal (nibbles above 9 shown blank)
//   in_lzb    leading-zero blanking enable
//   in_blink  per-digit blink mask
//   seg_n     active-low segments, bit6 = a .. bit0 = g (registered)
//   an_n      active-low one-hot digit select (registered)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NDIG         = 8,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic              in_hex,
  input  logic              in_lzb,
  input  logic [NDIG-1:0]   in_blink,
  output logic [6:0]        seg_n,
  output logic [NDIG-1:0]   an_n
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NDIG);
  // The +1 keeps the counter at least one bit wide when BLINK_FRAMES is 1.
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     presc_reg;
  logic [IW-1:0]     idx_reg;
  logic [FW-1:0]     frame_cnt_reg;
  logic              phase_reg;
  logic              pending_reg;

  logic [4*NDIG-1:0] pend_data_reg;
  logic              pend_hex_reg;
  logic              pend_lzb_reg;
  logic [NDIG-1:0]   pend_blink_reg;

  logic [4*NDIG-1:0] disp_data_reg;
  logic              disp_hex_reg;
  logic              disp_lzb_reg;
  logic [NDIG-1:0]   disp_blink_reg;

  logic [6:0]        seg_n_reg;
  logic [NDIG-1:0]   an_n_reg;

  logic [6:0]        seg_n_next;
  logic [NDIG-1:0]   an_n_next;

  logic              tick;
  logic              frame_end;
  logic              accept;

  assign tick      = (presc_reg == PRESC_LAST);
  assign frame_end = tick && (idx_reg == IDX_LAST);
  assign in_ready  = !pending_reg;
  assign accept    = in_valid && in_ready;

  assign seg_n = seg_n_reg;
  assign an_n  = an_n_reg;

  // ---------------------------------------------------------------------------
  // Per-digit view of the displayed word
  // ---------------------------------------------------------------------------
  logic [3:0]      nib [NDIG];
  // hi_zero[i]: digits i..NDIG-1 are all zero. hi_zero[NDIG] is the seed.
  logic [NDIG:0]   hi_zero;
  logic [NDIG-1:0] dark;

  assign hi_zero[NDIG] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign nib[gi]     = disp_data_reg[4*gi +: 4];
      assign hi_zero[gi] = (nib[gi] == 4'h0) && hi_zero[gi+1];
      if (gi == 0) begin : g_units
        // The units digit always shows, so an all-zero word still reads "0".
        assign dark[gi] = disp_blink_reg[gi] && phase_reg;
      end else begin : g_upper
        assign dark[gi] = (disp_blink_reg[gi] && phase_reg) ||
                          (disp_lzb_reg && hi_zero[gi]);
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Glyph decode, active-low a..g
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    // Decimal mode leaves A-F as dark segments while the anode stays driven.
    if (!hex && (n > 4'h9)) begin
      g = SEG_BLANK;
    end
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Next output value. The last cycle of every slot is blanked here, and the
  // register below makes that blank land on the first cycle of the next slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_n_next = SEG_BLANK;
    an_n_next  = '1;
    if (!tick && !dark[idx_reg]) begin
      an_n_next  = ~(NDIG'(1) << idx_reg);
      seg_n_next = glyph(nib[idx_reg], disp_hex_reg);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else begin
      if (tick) begin
        presc_reg <= '0;
        idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase: toggles once every BLINK_FRAMES frames
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt_reg == FRAME_LAST) begin
        frame_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending buffer and commit into the display registers.
  // An accept can only happen while nothing is pending, so it never collides
  // with a commit. A word captured on a frame_end cycle waits for the next one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg    <= 1'b0;
      pend_data_reg  <= '0;
      pend_hex_reg   <= 1'b0;
      pend_lzb_reg   <= 1'b0;
      pend_blink_reg <= '0;
      disp_data_reg  <= '0;
      disp_hex_reg   <= 1'b0;
      disp_lzb_reg   <= 1'b0;
      disp_blink_reg <= '0;
    end else begin
      if (accept) begin
        pending_reg    <= 1'b1;
        pend_data_reg  <= in_data;
        pend_hex_reg   <= in_hex;
        pend_lzb_reg   <= in_lzb;
        pend_blink_reg <= in_blink;
      end else if (frame_end && pending_reg) begin
        pending_reg    <= 1'b0;
        disp_data_reg  <= pend_data_reg;
        disp_hex_reg   <= pend_hex_reg;
        disp_lzb_reg   <= pend_lzb_reg;
        disp_blink_reg <= pend_blink_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n_reg <= SEG_BLANK;
      an_n_reg  <= '1;
    end else begin
      seg_n_reg <= seg_n_next;
      an_n_reg  <= an_n_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Directed and randomized stimulus for seg_scan_ctrl (NDIG=4, CLK_DIV=4,
// BLINK_FRAMES=2). The expected display comes from a reference model that
// works only from the cycle count since reset and the words it has accepted.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BF = 2;
  localparam int F  = ND * CD;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4*ND-1:0] in_data;
  logic            in_hex;
  logic            in_lzb;
  logic [ND-1:0]   in_blink;
  logic [6:0]      seg_n;
  logic [ND-1:0]   an_n;

  seg_scan_ctrl #(
    .NDIG        (ND),
    .CLK_DIV     (CD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_hex  (in_hex),
    .in_lzb  (in_lzb),
    .in_blink(in_blink),
    .seg_n   (seg_n),
    .an_n    (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        hex;
    logic        lzb;
    logic [3:0]  blink;
  } word_t;

  logic [6:0] gly [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                           7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int    vectors;
  int    miscompares;
  int    k;          // cycles since reset release
  bit    m_pend;
  word_t m_pend_w;
  word_t m_disp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Output the display should present after the clock edge that ends cycle k.
  task automatic expect_out(output logic [3:0] ean, output logic [6:0] eseg);
    int  slot;
    int  phase;
    int  nibv;
    bit  dark;
    slot  = (k / CD) % ND;
    phase = ((k / F) / BF) % 2;
    ean   = 4'hF;
    eseg  = 7'h7F;
    if ((k % CD) != CD - 1) begin
      nibv = int'((m_disp.d >> (4 * slot)) & 16'hF);
      dark = (m_disp.blink[slot] && phase == 1) ||
             (m_disp.lzb && slot != 0 && (m_disp.d >> (4 * slot)) == 16'h0);
      if (!dark) begin
        ean  = ~(4'(1) << slot);
        eseg = (!m_disp.hex && nibv > 9) ? 7'h7F : gly[nibv];
      end
    end
  endtask

  task automatic step(output bit acc);
    logic [3:0] ean;
    logic [6:0] eseg;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
    expect_out(ean, eseg);
    acc = in_valid && !m_pend;
    if (((k % F) == F - 1) && m_pend) begin
      m_disp = m_pend_w;
      m_pend = 1'b0;
    end
    if (acc) begin
      m_pend_w.d     = in_data;
      m_pend_w.hex   = in_hex;
      m_pend_w.lzb   = in_lzb;
      m_pend_w.blink = in_blink;
      m_pend         = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("an_n", {28'd0, an_n}, {28'd0, ean});
    chk("seg_n", {25'd0, seg_n}, {25'd0, eseg});
    k++;
  endtask

  task automatic run(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic offer(input logic [15:0] d, input logic hex, input logic lzb,
                       input logic [3:0] blink);
    bit acc;
    acc      = 1'b0;
    in_data  = d;
    in_hex   = hex;
    in_lzb   = lzb;
    in_blink = blink;
    in_valid = 1'b1;
    for (int i = 0; i < 3 * F && !acc; i++) step(acc);
    chk("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    $display("offer data=%04h hex=%0d lzb=%0d blink=%04b accepted at k=%0d", d, hex, lzb, blink, k);
  endtask

  task automatic model_reset();
    k        = 0;
    m_pend   = 1'b0;
    m_pend_w = '0;
    m_disp   = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_hex      = 1'b0;
    in_lzb      = 1'b0;
    in_blink    = '0;
    model_reset();

    // 1. Reset state, then an empty "0000" scan
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an_n", {28'd0, an_n}, 32'hF);
    chk("rst_seg_n", {25'd0, seg_n}, 32'h7F);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    run(2 * F);

    // 2. Decimal load accepted mid-frame
    run(5);
    offer(16'h1234, 1'b0, 1'b0, 4'b0000);
    run(2 * F);

    // 3. Hex mode, then the same word in decimal mode
    offer(16'hABCD, 1'b1, 1'b0, 4'b0000);
    run(2 * F);
    offer(16'hABCD, 1'b0, 1'b0, 4'b0000);
    run(2 * F);

    // 4. Leading-zero blanking
    offer(16'h0070, 1'b0, 1'b1, 4'b0000);
    run(2 * F);
    offer(16'h0000, 1'b0, 1'b1, 4'b0000);
    run(2 * F);

    // 5. Back-to-back words under backpressure
    offer(16'h1111, 1'b0, 1'b0, 4'b0000);
    offer(16'h2222, 1'b0, 1'b0, 4'b0000);
    run(2 * F);

    // 6. Blink on digit 0
    offer(16'h5555, 1'b0, 1'b0, 4'b0001);
    run(9 * F + 3);

    // Randomized words and gaps
    for (int r = 0; r < 8; r++) begin
      offer(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      run($urandom_range(0, 40));
    end

    // Asynchronous reset in the middle of a blinking display
    offer(16'h5555, 1'b0, 1'b0, 4'b0001);
    run(3 * F + 6);
    offer(16'h9876, 1'b0, 1'b0, 4'b0000);
    rst = 1'b1;
    #1;
    chk("midrst_an_n", {28'd0, an_n}, 32'hF);
    chk("midrst_seg_n", {25'd0, seg_n}, 32'h7F);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    model_reset();
    run(2 * F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
